// File: rtl/eth_rst_sequencer.sv
// Reset sequencer for the 1G Ethernet PHY path and the SoC/PTP domain behind it.
// Optional status LED output led_n is enabled by defining ETH_RST_SEQ_STATUS_LED_EN.
`timescale 1ns/1ps
module eth_rst_sequencer #(
  parameter int unsigned RST_CYCLES      = 2500000,
  parameter int unsigned LOCK_TIMEOUT    = 50000000,
  parameter int unsigned LINKDOWN_FILTER = 500000,
  parameter int unsigned MAX_RETRY       = 3,
  parameter logic [1:0]  PORT_MASK       = 2'b01
) (
  input  logic                           c10_clk50m,
  input  logic                           clean_rst_long_n,
  input  logic [1:0]                     link_up_async,
  input  logic                           force_rst,
  input  logic                           retry_req,
  output logic                           phy_rst_n,
  output logic                           soc_rst_n,
  output logic [1:0]                     state_o,
  output logic                           fault,
  output logic [$clog2(MAX_RETRY+1)-1:0] retry_cnt,
  output logic [7:0]                     link_drop_cnt
`ifdef ETH_RST_SEQ_STATUS_LED_EN
  ,
  output logic                           led_n
`endif
);

  function automatic int unsigned max3(input int unsigned a, input int unsigned b,
                                       input int unsigned c);
    int unsigned m;
    m = (a > b) ? a : b;
    return (m > c) ? m : c;
  endfunction

  localparam int unsigned CNT_MAX = max3(RST_CYCLES, LOCK_TIMEOUT, LINKDOWN_FILTER);
  localparam int unsigned CNT_W   = (CNT_MAX > 1) ? $clog2(CNT_MAX) : 1;
  localparam int unsigned RETRY_W = $clog2(MAX_RETRY + 1);

  localparam logic [CNT_W-1:0]   HOLD_LAST = CNT_W'(RST_CYCLES - 1);
  localparam logic [CNT_W-1:0]   LOCK_LAST = CNT_W'(LOCK_TIMEOUT - 1);
  localparam logic [CNT_W-1:0]   DROP_LAST = CNT_W'(LINKDOWN_FILTER - 1);
  localparam logic [RETRY_W-1:0] RETRY_MAX = RETRY_W'(MAX_RETRY);

  typedef enum logic [1:0] {
    S_HOLD      = 2'd0,
    S_WAIT_LINK = 2'd1,
    S_RUN       = 2'd2,
    S_FAULT     = 2'd3
  } state_t;

  logic [1:0]         link_meta_q;
  logic [1:0]         link_s_q;
  logic               req_ok;
  state_t             state_q,  state_d;
  logic [CNT_W-1:0]   cnt_q,    cnt_d;
  logic [RETRY_W-1:0] retry_q,  retry_d;
  logic [7:0]         drop_q,   drop_d;
  logic               phy_q,    phy_d;
  logic               soc_q,    soc_d;
  logic               fault_q,  fault_d;

  assign req_ok = ((link_s_q & PORT_MASK) == PORT_MASK);

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    retry_d = retry_q;
    drop_d  = drop_q;
    if (force_rst) begin
      state_d = S_HOLD;
      cnt_d   = '0;
      retry_d = '0;
    end else begin
      case (state_q)
        S_HOLD: begin
          if (cnt_q == HOLD_LAST) begin
            state_d = S_WAIT_LINK;
            cnt_d   = '0;
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end
        S_WAIT_LINK: begin
          // A lock seen in the timeout cycle still counts as a lock.
          if (req_ok) begin
            state_d = S_RUN;
            cnt_d   = '0;
            retry_d = '0;
          end else if (cnt_q == LOCK_LAST) begin
            cnt_d   = '0;
            retry_d = retry_q + 1'b1;
            state_d = (retry_d == RETRY_MAX) ? S_FAULT : S_HOLD;
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end
        S_RUN: begin
          if (req_ok) begin
            cnt_d = '0;
          end else if (cnt_q == DROP_LAST) begin
            state_d = S_HOLD;
            cnt_d   = '0;
            if (drop_q != 8'hFF) drop_d = drop_q + 8'd1;
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end
        S_FAULT: begin
          if (retry_req) begin
            state_d = S_HOLD;
            cnt_d   = '0;
            retry_d = '0;
          end
        end
        default: begin
          state_d = S_HOLD;
          cnt_d   = '0;
        end
      endcase
    end
    // Outputs follow the next state so they switch on the transition edge.
    phy_d   = (state_d == S_WAIT_LINK) || (state_d == S_RUN);
    soc_d   = (state_d == S_RUN);
    fault_d = (state_d == S_FAULT);
  end

  always_ff @(posedge c10_clk50m or negedge clean_rst_long_n) begin
    if (!clean_rst_long_n) begin
      link_meta_q <= '0;
      link_s_q    <= '0;
      state_q     <= S_HOLD;
      cnt_q       <= '0;
      retry_q     <= '0;
      drop_q      <= '0;
      phy_q       <= 1'b0;
      soc_q       <= 1'b0;
      fault_q     <= 1'b0;
    end else begin
      link_meta_q <= link_up_async;
      link_s_q    <= link_meta_q;
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      retry_q     <= retry_d;
      drop_q      <= drop_d;
      phy_q       <= phy_d;
      soc_q       <= soc_d;
      fault_q     <= fault_d;
    end
  end

  assign phy_rst_n     = phy_q;
  assign soc_rst_n     = soc_q;
  assign state_o       = state_q;
  assign fault         = fault_q;
  assign retry_cnt     = retry_q;
  assign link_drop_cnt = drop_q;

`ifdef ETH_RST_SEQ_STATUS_LED_EN
  logic [23:0] blink_q;
  logic        led_q, led_d;

  always_comb begin
    led_d = led_q;
    case (state_d)
      S_HOLD:      led_d = 1'b1;
      S_RUN:       led_d = 1'b0;
      S_WAIT_LINK: if (&blink_q[21:0]) led_d = ~led_q;
      S_FAULT:     if (&blink_q) led_d = ~led_q;
      default:     led_d = 1'b1;
    endcase
  end

  always_ff @(posedge c10_clk50m or negedge clean_rst_long_n) begin
    if (!clean_rst_long_n) begin
      blink_q <= '0;
      led_q   <= 1'b1;
    end else begin
      blink_q <= blink_q + 24'd1;
      led_q   <= led_d;
    end
  end

  assign led_n = led_q;
`endif

endmodule

// File: tb/tb_eth_rst_sequencer.sv
// Scoreboard bench for eth_rst_sequencer with shortened timing parameters.
`timescale 1ns/1ps
module tb_eth_rst_sequencer;

  logic       clk;
  logic       rst_n;
  logic [1:0] link;
  logic       force_rst;
  logic       retry_req;
  logic       phy_rst_n;
  logic       soc_rst_n;
  logic [1:0] state_o;
  logic       fault;
  logic [1:0] retry_cnt;
  logic [7:0] link_drop_cnt;
`ifdef ETH_RST_SEQ_STATUS_LED_EN
  logic       led_n;
`endif

  eth_rst_sequencer #(
    .RST_CYCLES(10),
    .LOCK_TIMEOUT(20),
    .LINKDOWN_FILTER(5),
    .MAX_RETRY(2),
    .PORT_MASK(2'b01)
  ) dut (
    .c10_clk50m(clk),
    .clean_rst_long_n(rst_n),
    .link_up_async(link),
    .force_rst(force_rst),
    .retry_req(retry_req),
    .phy_rst_n(phy_rst_n),
    .soc_rst_n(soc_rst_n),
    .state_o(state_o),
    .fault(fault),
    .retry_cnt(retry_cnt),
    .link_drop_cnt(link_drop_cnt)
`ifdef ETH_RST_SEQ_STATUS_LED_EN
    ,
    .led_n(led_n)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    string       tag;
    logic [31:0] val;
  } exp_t;

  exp_t sb_q[$];
  int   n_tests = 0;
  int   n_fail  = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic sb_push(input string tag, input logic [31:0] v);
    exp_t e;
    e.tag = tag;
    e.val = v;
    sb_q.push_back(e);
  endtask

  task automatic sb_check(input logic [31:0] obs);
    exp_t e;
    if (sb_q.size() == 0) begin
      n_fail++;
      $display("FAIL sb_underflow: got %0d with no expectation queued", obs);
    end else begin
      e = sb_q.pop_front();
      chk(e.tag, obs, e.val);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic wait_state(input string tag, input logic [1:0] target, input int max_cyc);
    int k;
    k = 0;
    while (state_o !== target && k < max_cyc) begin
      tick(1);
      k++;
    end
    chk(tag, state_o, target);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n     = 1'b0;
    link      = 2'b01;
    force_rst = 1'b0;
    retry_req = 1'b0;
    tick(3);

    sb_push("rst_state", 0); sb_push("rst_phy", 0); sb_push("rst_soc", 0);
    sb_push("rst_fault", 0); sb_push("rst_retry", 0); sb_push("rst_drop", 0);
    sb_check(state_o); sb_check(phy_rst_n); sb_check(soc_rst_n);
    sb_check(fault); sb_check(retry_cnt); sb_check(link_drop_cnt);

    // Release with the required link up: 10 cycles of HOLD, then lock.
    sb_push("t1_phy_hold", 0);
    sb_push("t1_phy_rise", 1); sb_push("t1_state_wait", 1); sb_push("t1_soc_wait", 0);
    sb_push("t1_state_run", 2); sb_push("t1_soc_run", 1); sb_push("t1_retry", 0);
    rst_n = 1'b1;
    tick(9);  sb_check(phy_rst_n);
    tick(1);  sb_check(phy_rst_n); sb_check(state_o); sb_check(soc_rst_n);
    tick(1);  sb_check(state_o); sb_check(soc_rst_n); sb_check(retry_cnt);

    // 4-cycle glitch is filtered.
    sb_push("glitch_state", 2); sb_push("glitch_drop", 0);
    link = 2'b00; tick(4); link = 2'b01; tick(6);
    sb_check(state_o); sb_check(link_drop_cnt);

    // Sustained loss re-sequences.
    sb_push("loss_pre_state", 2);
    sb_push("loss_state", 0); sb_push("loss_phy", 0); sb_push("loss_soc", 0); sb_push("loss_drop", 1);
    link = 2'b00; tick(6); sb_check(state_o);
    tick(1); sb_check(state_o); sb_check(phy_rst_n); sb_check(soc_rst_n); sb_check(link_drop_cnt);
    link = 2'b01;
    wait_state("loss_recover", 2'd2, 30);

    // force_rst for 3 cycles in RUN.
    sb_push("frc_phy", 0); sb_push("frc_soc", 0); sb_push("frc_state", 0);
    sb_push("frc_hold9_state", 0); sb_push("frc_hold9_phy", 0);
    sb_push("frc_wait_state", 1); sb_push("frc_wait_phy", 1); sb_push("frc_drop", 1);
    force_rst = 1'b1; tick(1);
    sb_check(phy_rst_n); sb_check(soc_rst_n); sb_check(state_o);
    tick(2); force_rst = 1'b0;
    tick(9); sb_check(state_o); sb_check(phy_rst_n);
    tick(1); sb_check(state_o); sb_check(phy_rst_n); sb_check(link_drop_cnt);
    wait_state("frc_recover", 2'd2, 5);

    // Asynchronous reset mid-RUN clears outputs without a clock edge.
    sb_push("arst_state", 0); sb_push("arst_phy", 0); sb_push("arst_soc", 0); sb_push("arst_drop", 0);
    rst_n = 1'b0; #1;
    sb_check(state_o); sb_check(phy_rst_n); sb_check(soc_rst_n); sb_check(link_drop_cnt);

    // No link: two timeouts into FAULT, then retry_req.
    link = 2'b00;
    tick(2);
    rst_n = 1'b1;
    sb_push("to_wait", 1); sb_push("to_pre_state", 1); sb_push("to_pre_retry", 0);
    sb_push("to1_state", 0); sb_push("to1_retry", 1); sb_push("to1_phy", 0);
    sb_push("to_wait2", 1);
    sb_push("flt_state", 3); sb_push("flt_fault", 1); sb_push("flt_phy", 0);
    sb_push("flt_soc", 0); sb_push("flt_retry", 2);
    sb_push("flt_stay", 3);
    sb_push("rr_state", 0); sb_push("rr_fault", 0); sb_push("rr_retry", 0);
    tick(10); sb_check(state_o);
    tick(19); sb_check(state_o); sb_check(retry_cnt);
    tick(1);  sb_check(state_o); sb_check(retry_cnt); sb_check(phy_rst_n);
    tick(10); sb_check(state_o);
    tick(20); sb_check(state_o); sb_check(fault); sb_check(phy_rst_n);
    sb_check(soc_rst_n); sb_check(retry_cnt);
    tick(5);  sb_check(state_o);
    retry_req = 1'b1; tick(1); retry_req = 1'b0;
    sb_check(state_o); sb_check(fault); sb_check(retry_cnt);

    // force_rst clears a non-zero retry count.
    sb_push("frc_retry_pre", 1); sb_push("frc_retry_clr", 0); sb_push("frc_retry_state", 0);
    tick(30); sb_check(retry_cnt);
    force_rst = 1'b1; tick(1); force_rst = 1'b0;
    sb_check(retry_cnt); sb_check(state_o);

    // Only the unrequired port up: still faults after two attempts.
    rst_n = 1'b0; link = 2'b10; tick(2); rst_n = 1'b1;
    sb_push("p1_soc", 0); sb_push("p1_pre_state", 1); sb_push("p1_state", 3); sb_push("p1_fault", 1);
    tick(11); sb_check(soc_rst_n);
    tick(48); sb_check(state_o);
    tick(1);  sb_check(state_o); sb_check(fault);

    // Saturation of the link-drop counter.
    rst_n = 1'b0; link = 2'b01; tick(2); rst_n = 1'b1;
    wait_state("sat_run0", 2'd2, 20);
    for (int i = 1; i <= 260; i++) begin
      sb_push("sat_drop", (i > 255) ? 255 : i);
      link = 2'b00; tick(7); link = 2'b01;
      sb_check(link_drop_cnt);
      wait_state("sat_run", 2'd2, 30);
    end

    chk("sb_empty", sb_q.size(), 0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
